// File: rtl/mux2_arbiter_64_if.sv
// Handshake and debug bundle between two producers, the arbiter and the downstream consumer.
interface mux2_arbiter_64_if #(
    parameter int CNT_W = 16
);
    logic             I0_valid;
    logic [63:0]      I0;
    logic             I0_ready;
    logic             I1_valid;
    logic [63:0]      I1;
    logic             I1_ready;
    logic             o_valid;
    logic [63:0]      o;
    logic             o_src;
    logic             o_ready;
    logic             sel;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  I0_valid, I0, I1_valid, I1, o_ready,
        output I0_ready, I1_ready, o_valid, o, o_src, sel, cnt0, cnt1
    );

    modport master (
        output I0_valid, I0, I1_valid, I1, o_ready,
        input  I0_ready, I1_ready, o_valid, o, o_src, sel, cnt0, cnt1
    );
endinterface

// File: rtl/mux2_arbiter_64.sv
// Two-source round-robin / fixed-priority arbiter driving a 64-bit 2:1 mux select,
// with a one-entry registered output stage and per-source acceptance counters.
module mux2_arbiter_64 #(
    parameter int FIXED_PRI = 0,
    parameter int CNT_W     = 16
) (
    input logic              clk,
    input logic              rst,
    mux2_arbiter_64_if.slave bus
);
    localparam int DATA_W = 64;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               src_q, src_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic any_vld;
    logic grant;
    logic sel;
    logic load;

    // Grant depends only on valids and history, never on data.
    always_comb begin
        any_vld = bus.I0_valid | bus.I1_valid;
        if (bus.I0_valid && bus.I1_valid) begin
            grant = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
        end else begin
            grant = bus.I1_valid;
        end
        sel  = any_vld ? grant : last_q;
        load = !rst && ((state_q == EMPTY) || bus.o_ready) && any_vld;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (load) begin
            state_d = FULL;
            data_d  = sel ? bus.I1 : bus.I0;
            src_d   = sel;
            last_d  = sel;
            if (sel) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
        end else if ((state_q == FULL) && bus.o_ready) begin
            state_d = EMPTY;
        end
    end

    // Output register stage: last = 1 out of reset so source 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus.sel      = sel;
    assign bus.I0_ready = load && !grant;
    assign bus.I1_ready = load && grant;
    assign bus.o_valid  = (state_q == FULL);
    assign bus.o        = data_q;
    assign bus.o_src    = src_q;
    assign bus.cnt0     = cnt0_q;
    assign bus.cnt1     = cnt1_q;
endmodule

// File: tb/tb_mux2_arbiter_64.sv
// Directed scoreboard bench for mux2_arbiter_64: round-robin, fixed-priority and narrow-counter builds.
module tb_mux2_arbiter_64;
    localparam logic [63:0] A = 64'hA0A0_A0A0_A0A0_A0A0;
    localparam logic [63:0] B = 64'hB1B1_B1B1_B1B1_B1B1;
    localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux2_arbiter_64_if #(.CNT_W(16)) b0 ();
    mux2_arbiter_64_if #(.CNT_W(16)) b1 ();
    mux2_arbiter_64_if #(.CNT_W(4))  b2 ();

    mux2_arbiter_64 #(.FIXED_PRI(0), .CNT_W(16)) dut_rr (.clk(clk), .rst(rst), .bus(b0));
    mux2_arbiter_64 #(.FIXED_PRI(1), .CNT_W(16)) dut_fp (.clk(clk), .rst(rst), .bus(b1));
    mux2_arbiter_64 #(.FIXED_PRI(0), .CNT_W(4))  dut_w4 (.clk(clk), .rst(rst), .bus(b2));

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0] sb0[$];
    logic [64:0] sb1[$];
    logic [64:0] sb2[$];

    // Reference state for the round-robin instance
    logic        m_last;
    logic        m_full;
    logic [15:0] m_cnt0, m_cnt1;
    logic [63:0] m_o;
    logic        m_src;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic ordy);
        rst = 1'b1;
        b0.I0_valid = 1'b1; b0.I0 = A;
        b0.I1_valid = 1'b1; b0.I1 = B;
        b0.o_ready  = ordy;
        #1;
        check("rst_I0_ready", 64'(b0.I0_ready), 64'd0);
        check("rst_I1_ready", 64'(b0.I1_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        b0.I0_valid = 1'b0;
        b0.I1_valid = 1'b0;
        check("rst_o_valid", 64'(b0.o_valid), 64'd0);
        check("rst_o", b0.o, 64'd0);
        check("rst_o_src", 64'(b0.o_src), 64'd0);
        check("rst_cnt0", 64'(b0.cnt0), 64'd0);
        check("rst_cnt1", 64'(b0.cnt1), 64'd0);
        m_last = 1'b1; m_full = 1'b0;
        m_cnt0 = '0;   m_cnt1 = '0;
        m_o = '0;      m_src = 1'b0;
        sb0.delete();
    endtask

    task automatic step0(input logic v0, input logic [63:0] d0,
                         input logic v1, input logic [63:0] d1, input logic ordy);
        logic        g, ld, was_full;
        logic [64:0] e;
        b0.I0_valid = v0; b0.I0 = d0;
        b0.I1_valid = v1; b0.I1 = d1;
        b0.o_ready  = ordy;
        #1;
        g  = (v0 && v1) ? ~m_last : v1;
        ld = (!m_full || ordy) && (v0 || v1);
        was_full = m_full;
        check("sel", 64'(b0.sel), 64'((v0 || v1) ? g : m_last));
        check("I0_ready", 64'(b0.I0_ready), 64'(ld && !g));
        check("I1_ready", 64'(b0.I1_ready), 64'(ld && g));
        if (ld) begin
            sb0.push_back({g, g ? d1 : d0});
            m_last = g;
            if (g) m_cnt1 = m_cnt1 + 16'd1;
            else   m_cnt0 = m_cnt0 + 16'd1;
            m_full = 1'b1;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        @(posedge clk); #1;
        check("o_valid", 64'(b0.o_valid), 64'(m_full));
        if (ld) begin
            e = sb0.pop_front();
            m_o = e[63:0];
            m_src = e[64];
            check("o", b0.o, m_o);
            check("o_src", 64'(b0.o_src), 64'(m_src));
        end else if (was_full && m_full) begin
            check("o_hold", b0.o, m_o);
            check("o_src_hold", 64'(b0.o_src), 64'(m_src));
        end
        check("cnt0", 64'(b0.cnt0), 64'(m_cnt0));
        check("cnt1", 64'(b0.cnt1), 64'(m_cnt1));
    endtask

    initial begin
        logic [64:0] e;
        b0.I0_valid = 0; b0.I0 = '0; b0.I1_valid = 0; b0.I1 = '0; b0.o_ready = 0;
        b1.I0_valid = 0; b1.I0 = '0; b1.I1_valid = 0; b1.I1 = '0; b1.o_ready = 0;
        b2.I0_valid = 0; b2.I0 = '0; b2.I1_valid = 0; b2.I1 = '0; b2.o_ready = 0;

        // Both sources continuously valid: A,B,A,B...
        do_reset(1'b1);
        step0(1'b1, A, 1'b1, B, 1'b1);
        check("rr_first_o", b0.o, A);
        for (int i = 0; i < 9; i++) step0(1'b1, A, 1'b1, B, 1'b1);
        check("rr_cnt0_5", 64'(b0.cnt0), 64'd5);
        check("rr_cnt1_5", 64'(b0.cnt1), 64'd5);

        // Only source 1 valid, words 1..4
        do_reset(1'b1);
        for (int i = 1; i <= 4; i++) step0(1'b0, '0, 1'b1, 64'(i), 1'b1);
        check("s1_last_o", b0.o, 64'd4);
        check("s1_cnt1_4", 64'(b0.cnt1), 64'd4);
        check("s1_cnt0_0", 64'(b0.cnt0), 64'd0);

        // Backpressure, then release with no bubble
        do_reset(1'b1);
        step0(1'b1, D, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step0(1'b1, D, 1'b1, B, 1'b0);
        check("bp_held", b0.o, D);
        step0(1'b1, D, 1'b1, B, 1'b1);
        check("bp_reload", b0.o, B);
        check("bp_no_bubble", 64'(b0.o_valid), 64'd1);

        // Drain, idle, then contention resumes from previous winner (source 1)
        step0(1'b0, '0, 1'b0, '0, 1'b1);
        step0(1'b0, '0, 1'b0, '0, 1'b0);
        step0(1'b1, A, 1'b1, B, 1'b1);
        check("gap_alternate", 64'(b0.o_src), 64'd0);

        // Reset while FULL and stalled
        step0(1'b1, A, 1'b1, B, 1'b1);
        step0(1'b1, A, 1'b1, B, 1'b0);
        do_reset(1'b0);
        step0(1'b1, A, 1'b1, B, 1'b1);
        check("post_rst_grant0", 64'(b0.o_src), 64'd0);

        // Fixed priority: source 0 always wins
        for (int i = 0; i < 6; i++) begin
            b1.I0_valid = 1'b1; b1.I0 = A + 64'(i);
            b1.I1_valid = 1'b1; b1.I1 = B;
            b1.o_ready  = 1'b1;
            #1;
            check("fp_I0_ready", 64'(b1.I0_ready), 64'd1);
            check("fp_I1_ready", 64'(b1.I1_ready), 64'd0);
            sb1.push_back({1'b0, A + 64'(i)});
            @(posedge clk); #1;
            e = sb1.pop_front();
            check("fp_o", b1.o, e[63:0]);
            check("fp_o_src", 64'(b1.o_src), 64'(e[64]));
        end
        b1.I0_valid = 1'b0; b1.I1_valid = 1'b0;
        check("fp_cnt1_0", 64'(b1.cnt1), 64'd0);
        check("fp_cnt0_6", 64'(b1.cnt0), 64'd6);

        // 4-bit counter wraps after 16 accepts
        for (int i = 1; i <= 17; i++) begin
            b2.I0_valid = 1'b1; b2.I0 = 64'(i);
            b2.o_ready  = 1'b1;
            #1;
            check("w4_I0_ready", 64'(b2.I0_ready), 64'd1);
            sb2.push_back({1'b0, 64'(i)});
            @(posedge clk); #1;
            e = sb2.pop_front();
            check("w4_o", b2.o, e[63:0]);
        end
        b2.I0_valid = 1'b0;
        check("w4_cnt0_wrap", 64'(b2.cnt0), 64'd1);
        check("w4_cnt1", 64'(b2.cnt1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
